// File: rtl/d_latch_one.sv
// d_latch_one: enable-gated holding register.
// Sync active-high reset, one-cycle capture.
module d_latch_one #(
  parameter int unsigned WIDTH = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // reset wins, else capture on ena, else hold
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (ena) begin
      q <= d;
    end
  end

endmodule

// File: tb/tb_d_latch_one.sv
// tb_d_latch_one: directed checks of d_latch_one.
// Covers 1-bit default and 8-bit A5 reset instances.
module tb_d_latch_one;

  logic       clk;
  logic       rst;
  logic       ena;
  logic [0:0] d;
  logic [0:0] q;

  logic       rst8;
  logic       ena8;
  logic [7:0] d8;
  logic [7:0] q8;

  int total;
  int bad;

  d_latch_one #(
    .WIDTH  (1),
    .RST_VAL(1'b0)
  ) u_dut1 (
    .clk(clk),
    .rst(rst),
    .ena(ena),
    .d  (d),
    .q  (q)
  );

  d_latch_one #(
    .WIDTH  (8),
    .RST_VAL(8'hA5)
  ) u_dut8 (
    .clk(clk),
    .rst(rst8),
    .ena(ena8),
    .d  (d8),
    .q  (q8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string      tag,
    input logic [7:0] obs,
    input logic [7:0] exp
  );
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    ena   = 1'b0;
    d     = 1'b0;
    rst8  = 1'b1;
    ena8  = 1'b0;
    d8    = 8'h00;
    #2;

    // 1: reset, then capture 0 and 1
    tick();
    chk("rst_q0", {7'd0, q}, 8'h00);
    chk("rst8_a5", q8, 8'hA5);
    rst = 1'b0;
    ena = 1'b1;
    d   = 1'b0;
    tick();
    tick();
    chk("cap_d0", {7'd0, q}, 8'h00);
    d = 1'b1;
    tick();
    chk("cap_d1_lat1", {7'd0, q}, 8'h01);
    tick();
    chk("cap_d1_hold", {7'd0, q}, 8'h01);

    // 2: hold with ena low
    ena = 1'b0;
    d   = 1'b1;
    tick();
    tick();
    chk("hold_d1", {7'd0, q}, 8'h01);
    d = 1'b0;
    tick();
    tick();
    chk("hold_d0", {7'd0, q}, 8'h01);

    // 3: reset mid-operation
    rst = 1'b1;
    tick();
    chk("midrst", {7'd0, q}, 8'h00);

    // 4: release, d toggles, ena low
    rst = 1'b0;
    d   = 1'b1;
    tick();
    tick();
    chk("post_rst_d1", {7'd0, q}, 8'h00);
    d = 1'b0;
    tick();
    tick();
    chk("post_rst_d0", {7'd0, q}, 8'h00);

    // 5: reset priority over enable
    rst = 1'b1;
    ena = 1'b1;
    d   = 1'b1;
    tick();
    chk("prio_1", {7'd0, q}, 8'h00);
    tick();
    chk("prio_2", {7'd0, q}, 8'h00);
    rst = 1'b0;
    tick();
    chk("prio_release", {7'd0, q}, 8'h01);

    // 6: d changes between edges
    d = 1'b0;
    #2;
    chk("mid_d0", {7'd0, q}, 8'h01);
    d = 1'b1;
    #2;
    chk("mid_d1", {7'd0, q}, 8'h01);
    d = 1'b0;
    #2;
    chk("mid_d0b", {7'd0, q}, 8'h01);
    tick();
    chk("edge_d0", {7'd0, q}, 8'h00);

    // 6: 8-bit capture, hold, reset
    rst8 = 1'b0;
    ena8 = 1'b1;
    d8   = 8'h3C;
    tick();
    chk("w8_cap", q8, 8'h3C);
    ena8 = 1'b0;
    d8   = 8'hFF;
    tick();
    tick();
    chk("w8_hold", q8, 8'h3C);
    ena8 = 1'b1;
    d8   = 8'hC3;
    tick();
    chk("w8_cap2", q8, 8'hC3);
    rst8 = 1'b1;
    tick();
    chk("w8_rst", q8, 8'hA5);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
